sar_adc_multi: RTL

Parametrised successive-approximation ADC controller for the PmodADC front end. It adds configurable resolution and timing, an N-channel input mux with round-robin scanning of enabled channels, and single-shot or continuous trigger modes. It drives the sample-and-hold, the serial DAC latch interface and the analog mux, and reads the comparator. It delivers tagged samples to the audio/data path.

---
 rtl/sar_adc_multi_pkg.sv | 40 ++++
 rtl/sar_adc_multi_if.sv | 34 +++
 rtl/sar_adc_multi_dac_shifter.sv | 51 +++++
 rtl/sar_adc_multi.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/sar_adc_multi_pkg.sv
// Shared types and helpers for the multi-channel SAR ADC controller.
// Provides the FSM state type, width helpers and the round-robin channel picker.
// No ports; imported by the interface, the top and the DAC serialiser.
package sar_adc_pkg;

  typedef enum logic [2:0] {IDLE, SAMPLE, SETTLE, BIT, DONE} state_t;

  // Select-field width; a single channel still needs one bit.
  function automatic int calc_cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must count 0..max(a,b,c)-1.
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  // First enabled channel at or after ptr, wrapping at n (n <= 16).
  // Walks downwards so the last hit is the nearest one to ptr.
  function automatic logic [3:0] next_chan(input logic [15:0] mask,
                                           input logic [3:0]  ptr,
                                           input int          n);
    logic [3:0] sel;
    int         idx;
    sel = '0;
    for (int i = 15; i >= 0; i--) begin
      if (i < n) begin
        idx = int'(ptr) + i;
        if (idx >= n) idx = idx - n;
        if (mask[idx[3:0]]) sel = idx[3:0];
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/sar_adc_multi_if.sv
// Bundles the ADC controller's trigger/config inputs, analog front-end pins and the
// tagged sample output. master = controller side, slave = front end / data consumer.
// Pure wiring, no latency; no backpressure on the sample path (one-cycle valid pulse).
interface sar_adc_multi_if #(
  parameter int RES_BITS = 14,
  parameter int CHANNELS = 4
);
  import sar_adc_pkg::*;
  localparam int CW = calc_cw(CHANNELS);

  logic                start_i;
  logic                continuous_i;
  logic [CHANNELS-1:0] chan_mask_i;
  logic                comp_i;
  logic                sh_o;
  logic [CW-1:0]       mux_sel_o;
  logic                ser_o;
  logic                sclk_o;
  logic                lclk_o;
  logic [RES_BITS-1:0] data_o;
  logic [CW-1:0]       chan_o;
  logic                data_valid_o;
  logic                busy_o;

  modport master (
    input  start_i, continuous_i, chan_mask_i, comp_i,
    output sh_o, mux_sel_o, ser_o, sclk_o, lclk_o, data_o, chan_o, data_valid_o, busy_o
  );

  modport slave (
    output start_i, continuous_i, chan_mask_i, comp_i,
    input  sh_o, mux_sel_o, ser_o, sclk_o, lclk_o, data_o, chan_o, data_valid_o, busy_o
  );
endinterface

// File: rtl/sar_adc_multi_dac_shifter.sv
// Serialises one DAC code per load pulse: per bit, sclk low then high, MSB first, then lclk.
// Latency: frame starts the cycle after load_i and lasts 2*DAC_BITS+1 cycles.
// No backpressure: caller must not load while busy_o is high.
// Ports: clk_i/reset_ni, load_i + data_i in; ser_o, sclk_o, lclk_o, busy_o out.
module dac_shifter #(
  parameter int DAC_BITS = 16
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                load_i,
  input  logic [DAC_BITS-1:0] data_i,
  output logic                ser_o,
  output logic                sclk_o,
  output logic                lclk_o,
  output logic                busy_o
);
  localparam int FW = $clog2(2 * DAC_BITS + 1);

  logic [DAC_BITS-1:0] r_sr;
  logic [FW-1:0]       r_cnt;
  logic                r_busy;
  logic                w_last;

  assign w_last = (r_cnt == FW'(2 * DAC_BITS));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (load_i) begin
      r_sr   <= data_i;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (w_last) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
        // Odd count is the sclk-high half; advance to the next bit after it.
        if (r_cnt[0]) r_sr <= r_sr << 1;
      end
    end
  end

  assign ser_o  = r_busy & ~w_last & r_sr[DAC_BITS-1];
  assign sclk_o = r_busy & ~w_last & r_cnt[0];
  assign lclk_o = r_busy & w_last;
  assign busy_o = r_busy;
endmodule

// File: rtl/sar_adc_multi.sv
// SAR ADC controller: round-robin channel scan, sample/settle/bit-trial sequencing, tagged result.
// Latency: SAMPLE_CYCLES+SETTLE_CYCLES+RES_BITS*BIT_CYCLES from trigger edge to the DONE cycle.
// No backpressure: data_valid_o is a one-cycle pulse; data_o/chan_o hold until the next one.
// Ports: clk_i, reset_ni (async, active-low); bus (master) carries triggers, mask, comparator,
// sample-and-hold, mux select, DAC serial pins and the result/valid/busy outputs.
module sar_adc_multi
  import sar_adc_pkg::*;
#(
  parameter int RES_BITS      = 14,
  parameter int DAC_BITS      = 16,
  parameter int CHANNELS      = 4,
  parameter int SAMPLE_CYCLES = 200,
  parameter int SETTLE_CYCLES = 30,
  parameter int BIT_CYCLES    = 45
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  sar_adc_multi_if.master  bus
);
  localparam int CW   = calc_cw(CHANNELS);
  localparam int CNTW = cnt_w(SAMPLE_CYCLES, SETTLE_CYCLES, BIT_CYCLES);
  localparam int KW   = calc_cw(RES_BITS);

  state_t              r_state, w_state_nxt;
  logic [CNTW-1:0]     r_cnt, w_cnt_nxt;
  logic [KW-1:0]       r_bit, w_bit_nxt;
  logic [RES_BITS-1:0] r_det, w_det_nxt, r_data, w_data_nxt, w_trial;
  logic [CW-1:0]       r_ptr, w_ptr_nxt, r_mux, w_mux_nxt, r_chan, w_chan_nxt, w_sel;
  logic                w_mask_nz, w_start_conv, w_load, w_dac_busy;

  assign w_mask_nz = |bus.chan_mask_i;
  assign w_sel     = CW'(next_chan(16'(bus.chan_mask_i), 4'(r_ptr), CHANNELS));
  assign w_trial   = r_det | (RES_BITS'(1) << (RES_BITS - 1 - int'(r_bit)));
  assign w_load    = (r_state == BIT) && (r_cnt == '0);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_det   <= '0;
      r_data  <= '0;
      r_ptr   <= '0;
      r_mux   <= '0;
      r_chan  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_det   <= w_det_nxt;
      r_data  <= w_data_nxt;
      r_ptr   <= w_ptr_nxt;
      r_mux   <= w_mux_nxt;
      r_chan  <= w_chan_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_bit_nxt    = r_bit;
    w_det_nxt    = r_det;
    w_data_nxt   = r_data;
    w_ptr_nxt    = r_ptr;
    w_mux_nxt    = r_mux;
    w_chan_nxt   = r_chan;
    w_start_conv = 1'b0;
    case (r_state)
      IDLE:   w_start_conv = (bus.start_i | bus.continuous_i) & w_mask_nz;
      SAMPLE: begin
        if (r_cnt == CNTW'(SAMPLE_CYCLES - 1)) begin
          w_state_nxt = SETTLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      SETTLE: begin
        if (r_cnt == CNTW'(SETTLE_CYCLES - 1)) begin
          w_state_nxt = BIT;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      BIT: begin
        if (r_cnt == CNTW'(BIT_CYCLES - 1)) begin
          w_cnt_nxt = '0;
          if (bus.comp_i) w_det_nxt = w_trial;
          if (r_bit == KW'(RES_BITS - 1)) begin
            // Result and tag are registered on entry so they line up with the valid pulse.
            w_state_nxt = DONE;
            w_data_nxt  = bus.comp_i ? w_trial : r_det;
            w_chan_nxt  = r_mux;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DONE: begin
        w_state_nxt  = IDLE;
        w_start_conv = bus.continuous_i & w_mask_nz;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Channel selection happens only here, so mask changes apply at the next pick.
    if (w_start_conv) begin
      w_state_nxt = SAMPLE;
      w_cnt_nxt   = '0;
      w_det_nxt   = '0;
      w_mux_nxt   = w_sel;
      w_ptr_nxt   = (w_sel == CW'(CHANNELS - 1)) ? '0 : w_sel + 1'b1;
    end
  end

  dac_shifter #(.DAC_BITS(DAC_BITS)) u_dac (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .load_i   (w_load),
    .data_i   (DAC_BITS'(w_trial)),
    .ser_o    (bus.ser_o),
    .sclk_o   (bus.sclk_o),
    .lclk_o   (bus.lclk_o),
    .busy_o   (w_dac_busy)
  );

  assign bus.sh_o         = (r_state == SAMPLE);
  assign bus.busy_o       = (r_state != IDLE);
  assign bus.data_valid_o = (r_state == DONE);
  assign bus.mux_sel_o    = r_mux;
  assign bus.data_o       = r_data;
  assign bus.chan_o       = r_chan;

  // A bit period must fit a whole DAC frame, and the frame must hold the code.
  a_params: assert property (@(posedge clk_i)
    (BIT_CYCLES >= 2 * DAC_BITS + 2) && (DAC_BITS >= RES_BITS));
  a_no_overlap: assert property (@(posedge clk_i) disable iff (!reset_ni)
    w_load |-> !w_dac_busy);
endmodule
